// File: rtl/fm_tune_ctrl.sv
// Retune and stereo-acquisition sequencer for the FM stereo receiver, paced by the sample strobe.
// Build option FM_TUNE_CTRL_SOFT_MUTE_EN: volume ramps step once per strobe; otherwise they jump in one clk.
module fm_tune_ctrl #(
  parameter int                   PHI_WIDTH      = 32,
  parameter int                   ERR_WIDTH      = 32,
  parameter int                   VOL_WIDTH      = 4,
  parameter logic [PHI_WIDTH-1:0] RESET_PHI      = '0,
  parameter int                   SETTLE_SAMPLES = 1024,
  parameter int                   LOCK_THRESH    = 65536,
  parameter int                   LOCK_COUNT     = 256,
  parameter int                   LOSS_COUNT     = 64,
  parameter int                   ACQ_TIMEOUT    = 8192
) (
  input  logic                        clk,
  input  logic                        areset,
  input  logic                        sample_valid,
  input  logic                        req_valid,
  input  logic [PHI_WIDTH-1:0]        req_phi_inc,
  output logic                        req_ready,
  input  logic signed [ERR_WIDTH-1:0] pilot_err,
  input  logic                        pilot_err_valid,
  input  logic [VOL_WIDTH-1:0]        volume_in,
  output logic [PHI_WIDTH-1:0]        phi_inc_o,
  output logic [VOL_WIDTH-1:0]        volume_o,
  output logic                        loop_hold_o,
  output logic                        stereo_o,
  output logic                        busy_o,
  output logic [2:0]                  state_o
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    RAMP_DOWN = 3'd1,
    RETUNE    = 3'd2,
    SETTLE    = 3'd3,
    ACQUIRE   = 3'd4,
    RAMP_UP   = 3'd5,
    RUN       = 3'd6
  } state_t;

  localparam int SET_W = $clog2(SETTLE_SAMPLES + 1);
  localparam int LCK_W = $clog2(LOCK_COUNT + 1);
  localparam int LOS_W = $clog2(LOSS_COUNT + 1);
  localparam int TMO_W = $clog2(ACQ_TIMEOUT + 1);

  localparam logic [ERR_WIDTH-1:0] ERR_MIN   = {1'b1, {(ERR_WIDTH-1){1'b0}}};
  localparam logic [ERR_WIDTH-1:0] ERR_MAX   = {1'b0, {(ERR_WIDTH-1){1'b1}}};
  localparam logic [ERR_WIDTH-1:0] THRESH_W  = ERR_WIDTH'(LOCK_THRESH);
  localparam logic [LCK_W-1:0]     LOCK_N    = LCK_W'(LOCK_COUNT);
  localparam logic [LOS_W-1:0]     LOSS_N    = LOS_W'(LOSS_COUNT);
  localparam logic [TMO_W-1:0]     TMO_N     = TMO_W'(ACQ_TIMEOUT);
  localparam logic [SET_W-1:0]     SETTLE_LAST = SET_W'(SETTLE_SAMPLES - 1);

  state_t               state;
  logic [PHI_WIDTH-1:0] phi_req;
  logic [SET_W-1:0]     settle_cnt;
  logic [LCK_W-1:0]     lock_cnt, lock_nxt;
  logic [LOS_W-1:0]     loss_cnt, loss_nxt;
  logic [TMO_W-1:0]     tmo_cnt, tmo_nxt;
  logic [ERR_WIDTH-1:0] err_abs;
  logic                 err_in;
  logic                 lock_hit, tmo_hit, loss_hit;

  assign state_o = state;

  // The most-negative error has no positive twin, so it saturates and always reads as out of threshold.
  always_comb begin
    err_abs = pilot_err[ERR_WIDTH-1] ? $unsigned(-pilot_err) : $unsigned(pilot_err);
    if ($unsigned(pilot_err) == ERR_MIN) err_abs = ERR_MAX;
    err_in = (err_abs < THRESH_W);
  end

  always_comb begin
    lock_nxt = lock_cnt;
    loss_nxt = loss_cnt;
    tmo_nxt  = tmo_cnt;
    if (pilot_err_valid) begin
      if (!err_in)               lock_nxt = '0;
      else if (lock_cnt != LOCK_N) lock_nxt = lock_cnt + 1'b1;
      if (err_in)                loss_nxt = '0;
      else if (loss_cnt != LOSS_N) loss_nxt = loss_cnt + 1'b1;
    end
    if (sample_valid && (tmo_cnt != TMO_N)) tmo_nxt = tmo_cnt + 1'b1;
    lock_hit = (lock_nxt == LOCK_N);
    loss_hit = (loss_nxt == LOSS_N);
    tmo_hit  = (tmo_nxt == TMO_N);
  end

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      state       <= SETTLE;
      phi_req     <= RESET_PHI;
      phi_inc_o   <= RESET_PHI;
      volume_o    <= '0;
      loop_hold_o <= 1'b1;
      stereo_o    <= 1'b0;
      req_ready   <= 1'b0;
      busy_o      <= 1'b1;
      settle_cnt  <= '0;
      lock_cnt    <= '0;
      loss_cnt    <= '0;
      tmo_cnt     <= '0;
    end else begin
      case (state)
        RAMP_DOWN: begin
          if (volume_o == '0) state <= RETUNE;
`ifdef FM_TUNE_CTRL_SOFT_MUTE_EN
          else if (sample_valid) volume_o <= volume_o - 1'b1;
`else
          else volume_o <= '0;
`endif
        end
        RETUNE: begin
          phi_inc_o   <= phi_req;
          loop_hold_o <= 1'b1;
          stereo_o    <= 1'b0;
          settle_cnt  <= '0;
          lock_cnt    <= '0;
          loss_cnt    <= '0;
          tmo_cnt     <= '0;
          state       <= SETTLE;
        end
        SETTLE: begin
          if (sample_valid) begin
            settle_cnt <= settle_cnt + 1'b1;
            if (settle_cnt == SETTLE_LAST) begin
              loop_hold_o <= 1'b0;
              state       <= ACQUIRE;
            end
          end
        end
        ACQUIRE: begin
          lock_cnt <= lock_nxt;
          tmo_cnt  <= tmo_nxt;
          // Lock is checked first so a lock landing on the timeout strobe still yields stereo.
          if (lock_hit) begin
            stereo_o <= 1'b1;
            state    <= RAMP_UP;
          end else if (tmo_hit) begin
            stereo_o <= 1'b0;
            state    <= RAMP_UP;
          end
        end
        RAMP_UP: begin
`ifdef FM_TUNE_CTRL_SOFT_MUTE_EN
          if (volume_o >= volume_in) begin
            volume_o  <= volume_in;
            state     <= RUN;
            req_ready <= 1'b1;
            busy_o    <= 1'b0;
          end else if (sample_valid) begin
            volume_o <= volume_o + 1'b1;
          end
`else
          volume_o  <= volume_in;
          state     <= RUN;
          req_ready <= 1'b1;
          busy_o    <= 1'b0;
`endif
        end
        RUN: begin
          volume_o <= volume_in;
          loss_cnt <= loss_nxt;
          if (loss_hit) stereo_o <= 1'b0;
          if (req_valid && req_ready) begin
            phi_req   <= req_phi_inc;
            state     <= RAMP_DOWN;
            req_ready <= 1'b0;
            busy_o    <= 1'b1;
          end
        end
        // IDLE and the spare encoding both recover by reloading the latched increment.
        default: state <= RETUNE;
      endcase
    end
  end

endmodule

// File: tb/tb_fm_tune_ctrl.sv
// Self-checking bench for fm_tune_ctrl: directed sequence with randomized errors checked against a
// strobe-level model of lock/timeout/loss rules. Runs with reduced counts to stay short.
module tb_fm_tune_ctrl;

  localparam int          SETTLE_N = 64;
  localparam int          LOCK_N   = 16;
  localparam int          LOSS_N   = 8;
  localparam int          ACQ_T    = 96;
  localparam logic [31:0] RST_PHI  = 32'h0123_4567;

  logic               clk = 1'b0;
  logic               areset = 1'b1;
  logic               sample_valid = 1'b0;
  logic               req_valid = 1'b0;
  logic [31:0]        req_phi_inc = '0;
  logic               req_ready;
  logic signed [31:0] pilot_err = '0;
  logic               pilot_err_valid = 1'b0;
  logic [3:0]         volume_in = 4'd9;
  logic [31:0]        phi_inc_o;
  logic [3:0]         volume_o;
  logic               loop_hold_o, stereo_o, busy_o;
  logic [2:0]         state_o;

  int errors = 0;
  int checks = 0;

  logic signed [31:0] acq_err [ACQ_T];
  bit                 acq_vld [ACQ_T];
  bit                 exp_stereo;
  int                 loss_run;
  logic [31:0]        cur_phi;
  logic [31:0]        new_phi;

  fm_tune_ctrl #(
    .PHI_WIDTH(32), .ERR_WIDTH(32), .VOL_WIDTH(4), .RESET_PHI(RST_PHI),
    .SETTLE_SAMPLES(SETTLE_N), .LOCK_THRESH(65536), .LOCK_COUNT(LOCK_N),
    .LOSS_COUNT(LOSS_N), .ACQ_TIMEOUT(ACQ_T)
  ) dut (
    .clk(clk), .areset(areset), .sample_valid(sample_valid), .req_valid(req_valid),
    .req_phi_inc(req_phi_inc), .req_ready(req_ready), .pilot_err(pilot_err),
    .pilot_err_valid(pilot_err_valid), .volume_in(volume_in), .phi_inc_o(phi_inc_o),
    .volume_o(volume_o), .loop_hold_o(loop_hold_o), .stereo_o(stereo_o),
    .busy_o(busy_o), .state_o(state_o)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One strobe-wide sample with its pilot error; returns on the negedge after it was clocked.
  task automatic apply_stimulus(input logic signed [31:0] e, input bit v);
    @(negedge clk);
    sample_valid = 1'b1; pilot_err = e; pilot_err_valid = v;
    @(negedge clk);
    sample_valid = 1'b0; pilot_err_valid = 1'b0;
  endtask

  function automatic bit in_thresh(input logic signed [31:0] e);
    longint a;
    a = (e < 0) ? -longint'(e) : longint'(e);
    return a < 65536;
  endfunction

  // Reference: strobe number at which acquisition ends and whether it ends in stereo.
  function automatic void predict_acquire(output int idx, output bit st);
    int run;
    run = 0; idx = ACQ_T; st = 1'b0;
    for (int i = 0; i < ACQ_T; i++) begin
      if (acq_vld[i]) run = in_thresh(acq_err[i]) ? run + 1 : 0;
      if (run >= LOCK_N) begin idx = i + 1; st = 1'b1; return; end
      if (i + 1 >= ACQ_T) begin idx = i + 1; st = 1'b0; return; end
    end
  endfunction

  task automatic run_settle(input int count, input bit pend, input string tag);
    for (int i = 1; i <= count; i++) begin
      req_valid   = pend && (i <= 4);
      req_phi_inc = 32'hDEAD_BEEF;
      apply_stimulus($urandom, 1'b1);
      if (pend && i == 4) begin
        check_output({tag, "_busy_ready"}, req_ready, 0);
        check_output({tag, "_busy_state"}, state_o, 3);
      end
      if (i == SETTLE_N - 1) begin
        check_output({tag, "_hold_pre"}, loop_hold_o, 1);
        check_output({tag, "_state_pre"}, state_o, 3);
      end
      if (i == SETTLE_N) begin
        check_output({tag, "_hold_drop"}, loop_hold_o, 0);
        check_output({tag, "_state_acq"}, state_o, 4);
      end
      idle($urandom_range(0, 2));
    end
    req_valid = 1'b0;
  endtask

  task automatic run_acquire(input string tag, output bit st);
    int idx;
    predict_acquire(idx, st);
    for (int i = 0; i < idx; i++) begin
      apply_stimulus(acq_err[i], acq_vld[i]);
      if (i == idx - 2) check_output({tag, "_still_acq"}, state_o, 4);
      if (i < idx - 1) idle($urandom_range(0, 2));
    end
    check_output({tag, "_state_up"}, state_o, 5);
    check_output({tag, "_stereo"}, stereo_o, st);
  endtask

  task automatic run_ramp_up(input string tag);
    for (int n = 1; n <= 12; n++) begin
      apply_stimulus(0, 1'b1);
`ifdef FM_TUNE_CTRL_SOFT_MUTE_EN
      if (n == 3) check_output({tag, "_vol_step"}, volume_o, 3);
`endif
      idle($urandom_range(0, 1));
    end
    check_output({tag, "_vol"}, volume_o, 9);
    check_output({tag, "_state_run"}, state_o, 6);
    check_output({tag, "_busy"}, busy_o, 0);
    check_output({tag, "_ready"}, req_ready, 1);
    check_output({tag, "_stereo_hold"}, stereo_o, exp_stereo);
    loss_run = 0;
  endtask

  task automatic run_loss_step(input logic signed [31:0] e, input bit v, input string tag);
    apply_stimulus(e, v);
    if (v) loss_run = in_thresh(e) ? 0 : loss_run + 1;
    if (loss_run >= LOSS_N) exp_stereo = 1'b0;
    check_output(tag, stereo_o, exp_stereo);
  endtask

  task automatic do_tune(input logic [31:0] phi, input string tag);
    req_valid = 1'b1; req_phi_inc = phi;
    @(negedge clk);
    req_valid = 1'b0;
    check_output({tag, "_accept_state"}, state_o, 1);
    check_output({tag, "_accept_ready"}, req_ready, 0);
    check_output({tag, "_accept_busy"}, busy_o, 1);
`ifdef FM_TUNE_CTRL_SOFT_MUTE_EN
    for (int n = 1; n <= 9; n++) begin
      apply_stimulus(0, 1'b0);
      check_output({tag, "_ramp_vol"}, volume_o, 9 - n);
      check_output({tag, "_ramp_state"}, state_o, 1);
    end
`else
    @(negedge clk);
    check_output({tag, "_mute_vol"}, volume_o, 0);
    check_output({tag, "_mute_state"}, state_o, 1);
`endif
    @(negedge clk);
    check_output({tag, "_retune_state"}, state_o, 2);
    check_output({tag, "_phi_old"}, phi_inc_o, cur_phi);
    @(negedge clk);
    check_output({tag, "_phi_new"}, phi_inc_o, phi);
    check_output({tag, "_hold"}, loop_hold_o, 1);
    check_output({tag, "_stereo_clr"}, stereo_o, 0);
    check_output({tag, "_state_settle"}, state_o, 3);
    check_output({tag, "_ready"}, req_ready, 0);
    cur_phi = phi;
  endtask

  function automatic logic [31:0] fresh_phi();
    logic [31:0] p;
    p = $urandom;
    if (p == cur_phi || p == RST_PHI) p = ~p;
    return p;
  endfunction

  initial begin
    cur_phi = RST_PHI;
    idle(3);
    check_output("rst_phi", phi_inc_o, RST_PHI);
    check_output("rst_vol", volume_o, 0);
    check_output("rst_hold", loop_hold_o, 1);
    check_output("rst_stereo", stereo_o, 0);
    check_output("rst_ready", req_ready, 0);
    check_output("rst_busy", busy_o, 1);
    check_output("rst_state", state_o, 3);
    areset = 1'b0;

    $display("[TB] boot acquisition with random errors");
    run_settle(SETTLE_N, 1'b0, "boot");
    for (int i = 0; i < ACQ_T; i++) begin
      acq_vld[i] = ($urandom_range(0, 7) != 0);
      acq_err[i] = ($urandom_range(0, 19) == 0) ? 32'(65536 + $urandom_range(0, 1000000))
                                                : 32'(int'($urandom_range(0, 131070)) - 65535);
    end
    run_acquire("boot_acq", exp_stereo);
    run_ramp_up("boot_up");

    $display("[TB] loss of lock in RUN");
    for (int i = 0; i < 24; i++) begin
      bit out;
      out = ($urandom_range(0, 3) == 0);
      run_loss_step(out ? 32'(70000 + $urandom_range(0, 100000)) : 32'($urandom_range(0, 65535)),
                    $urandom_range(0, 5) != 0, "loss_rand");
    end
    for (int i = 0; i < LOSS_N - 1; i++) run_loss_step(70000, 1'b1, "loss_short");
    run_loss_step(0, 1'b1, "loss_break");
    for (int i = 0; i < LOSS_N; i++) run_loss_step(70000, 1'b1, "loss_full");

    $display("[TB] tune to 0x0CAB0000, threshold edges");
    do_tune(32'h0CAB_0000, "tune1");
    run_settle(SETTLE_N, 1'b1, "tune1_settle");
    for (int i = 0; i < ACQ_T; i++) begin acq_vld[i] = 1'b1; acq_err[i] = 0; end
    for (int i = 0; i < 15; i++) acq_err[i] = 65535;
    acq_err[15] = 65536;
    for (int i = 16; i < 31; i++) acq_err[i] = -65535;
    acq_err[31] = 32'sh8000_0000;
    for (int i = 32; i < 48; i++) acq_err[i] = 65535;
    run_acquire("edge_acq", exp_stereo);
    run_ramp_up("edge_up");

    $display("[TB] acquisition timeout");
    new_phi = fresh_phi();
    do_tune(new_phi, "tune2");
    run_settle(SETTLE_N, 1'b0, "tune2_settle");
    for (int i = 0; i < ACQ_T; i++) begin acq_vld[i] = 1'b1; acq_err[i] = 200000; end
    run_acquire("tmo_acq", exp_stereo);
    run_ramp_up("tmo_up");

    $display("[TB] mid-settle reset, simultaneous lock/timeout, clamp");
    new_phi = fresh_phi();
    do_tune(new_phi, "tune3");
    run_settle(20, 1'b0, "tune3_part");
    @(negedge clk);
    areset = 1'b1;
    #1;
    check_output("mid_rst_phi", phi_inc_o, RST_PHI);
    check_output("mid_rst_vol", volume_o, 0);
    check_output("mid_rst_state", state_o, 3);
    check_output("mid_rst_hold", loop_hold_o, 1);
    cur_phi = RST_PHI;
    @(negedge clk);
    areset = 1'b0;
    run_settle(SETTLE_N, 1'b0, "post_rst_settle");
    for (int i = 0; i < ACQ_T; i++) begin
      acq_vld[i] = 1'b1;
      acq_err[i] = (i < ACQ_T - LOCK_N) ? 32'sd200000 : 32'(int'($urandom_range(0, 131070)) - 65535);
    end
    run_acquire("tie_acq", exp_stereo);
    for (int n = 0; n < 5; n++) apply_stimulus(0, 1'b1);
`ifdef FM_TUNE_CTRL_SOFT_MUTE_EN
    check_output("clamp_pre_vol", volume_o, 5);
`endif
    volume_in = 4'd3;
    @(negedge clk);
    check_output("clamp_vol", volume_o, 3);
    check_output("clamp_state", state_o, 6);
    check_output("clamp_stereo", stereo_o, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
